ram_bank: RTL and testbench

//   Parametrised synchronous single-port RAM; successor to the fixed 32x32 ram.

---
 rtl/ram_bank.sv | 112 +++++++++++
 tb/tb_ram_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram_bank.sv
// Parametrised single-port RAM with per-byte write enables, a registered read port,
// selectable read-during-write behaviour and a sequential clear engine.

module ram_bank_lane (
  input  logic       i_be,
  input  logic [7:0] i_old,
  input  logic [7:0] i_new,
  output logic [7:0] o_byte
);
  assign o_byte = i_be ? i_new : i_old;
endmodule

module ram_bank #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    cen,
  input  logic                    wen,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   S_addr,
  input  logic [DATA_WIDTH-1:0]   S_din,
  output logic [DATA_WIDTH-1:0]   S_dout,
  output logic                    S_valid,
  output logic                    busy
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic                    w_done;
  logic                    w_acc;
  logic                    w_wr;

  assign w_old  = r_mem[S_addr];
  assign w_done = (r_cnt == LAST);
  // clr wins over a port access in the same IDLE cycle
  assign w_acc  = (r_state == ST_IDLE) && !clr && cen;
  assign w_wr   = w_acc && wen;

  genvar g;
  generate
    for (g = 0; g < NB; g++) begin : g_lane
      ram_bank_lane u_lane (
        .i_be   (be[g]),
        .i_old  (w_old[8*g +: 8]),
        .i_new  (S_din[8*g +: 8]),
        .o_byte (w_merged[8*g +: 8])
      );
    end
  endgenerate

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (clr)    w_next_state = ST_CLEAR;
      ST_CLEAR: if (w_done) w_next_state = ST_IDLE;
      default:              w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_busy  <= (CLEAR_ON_RESET != 0);
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_CLEAR);
      if (r_state == ST_CLEAR) r_cnt <= r_cnt + 1'b1;
      else if (clr)            r_cnt <= '0;
    end
  end

  // Array has no reset; only the clear engine or the port modifies it
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) r_mem[r_cnt]  <= '0;
      else if (w_wr)           r_mem[S_addr] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_acc;
      if (w_acc) r_dout <= (wen && WRITE_MODE != 0) ? w_merged : w_old;
    end
  end

  assign S_dout  = r_dout;
  assign S_valid = r_valid;
  assign busy    = r_busy;
endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: read-first and write-first instances share stimulus
// and are checked every cycle against a word-level model, plus literal spot checks.

module tb_ram_bank;
  logic        clk = 1'b0;
  logic        reset, clr, cen, wen;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout0, dout1;
  logic        valid0, valid1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) u_rf (
    .clk(clk), .reset(reset), .clr(clr), .cen(cen), .wen(wen), .be(be),
    .S_addr(addr), .S_din(din), .S_dout(dout0), .S_valid(valid0), .busy(busy0));

  ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_MODE(1), .CLEAR_ON_RESET(1)) u_wf (
    .clk(clk), .reset(reset), .clr(clr), .cen(cen), .wen(wen), .be(be),
    .S_addr(addr), .S_din(din), .S_dout(dout1), .S_valid(valid1), .busy(busy1));

  // Word-level model: a clear makes the array read as zero once busy ends,
  // since no access can observe it mid-clear.
  logic [31:0] m_mem [32];
  logic [31:0] m_dout0, m_dout1, m_old, m_merged;
  logic        m_valid;
  int          m_left;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_dout0 = 0; m_dout1 = 0; m_valid = 0; m_left = 32;
      for (int i = 0; i < 32; i++) m_mem[i] = 0;
      chk_en = 1;
    end else if (m_left > 0) begin
      m_left--; m_valid = 0;
    end else if (clr) begin
      m_left = 32; m_valid = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = 0;
    end else if (cen) begin
      m_old = m_mem[addr];
      m_merged = m_old;
      for (int b = 0; b < 4; b++) if (be[b]) m_merged[8*b +: 8] = din[8*b +: 8];
      m_dout0 = m_old;
      m_dout1 = wen ? m_merged : m_old;
      if (wen) m_mem[addr] = m_merged;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy0 !== (m_left > 0) || busy1 !== (m_left > 0) || valid0 !== m_valid ||
          valid1 !== m_valid || dout0 !== m_dout0 || dout1 !== m_dout1) begin
        errors++;
        $display("FAIL model t=%0t busy=%b/%b valid=%b/%b dout=%h/%h want busy=%b valid=%b dout=%h/%h",
                 $time, busy0, busy1, valid0, valid1, dout0, dout1, (m_left > 0), m_valid, m_dout0, m_dout1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic acc(input logic w, input logic [3:0] b, input logic [4:0] a, input logic [31:0] d);
    cen = 1; wen = w; be = b; addr = a; din = d;
    step();
    cen = 0; wen = 0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      step();
    end
    chk(name, n, 32);
  endtask

  logic [31:0] hold;

  initial begin
    reset = 1; clr = 0; cen = 0; wen = 0; be = 0; addr = 0; din = 0;
    step(); step();
    chk("reset_dout", dout0, 0);
    chk("reset_valid", {31'b0, valid0}, 0);
    reset = 0;

    // Auto-clear after reset, then every word reads zero
    count_busy("busy_after_reset");
    for (int i = 0; i < 32; i++) begin
      acc(0, 4'h0, 5'(i), 0);
      chk("clear_read", dout0, 0);
    end

    // Full-word writes then reads
    for (int i = 1; i <= 4; i++) acc(1, 4'hF, 5'(i), 32'(i));
    for (int i = 1; i <= 4; i++) begin
      acc(0, 4'h0, 5'(i), 0);
      chk("read_back", dout0, 32'(i));
      chk("read_valid", {31'b0, valid0}, 1);
    end
    step();
    chk("idle_valid", {31'b0, valid0}, 0);

    // Byte-masked merge
    acc(1, 4'hF, 5'd5, 32'hAABBCCDD);
    acc(1, 4'b0101, 5'd5, 32'h11223344);
    acc(0, 4'h0, 5'd5, 0);
    chk("byte_merge", dout0, 32'hAA22CC44);

    // Read-during-write: old word vs merged word
    acc(1, 4'hF, 5'd7, 32'h9);
    acc(1, 4'hF, 5'd7, 32'h5);
    chk("rdw_mode0", dout0, 32'h9);
    chk("rdw_mode1", dout1, 32'h5);
    chk("rdw_valid", {31'b0, valid1}, 1);
    acc(0, 4'h0, 5'd7, 0);
    chk("read_after_write", dout0, 32'h5);

    // be==0 write: no change, still valid
    acc(1, 4'h0, 5'd7, 32'hFFFFFFFF);
    chk("be0_valid", {31'b0, valid0}, 1);
    acc(0, 4'h0, 5'd7, 0);
    chk("be0_nochange", dout0, 32'h5);

    // clr request; port writes during busy are dropped
    clr = 1; step(); clr = 0;
    cen = 1; wen = 1; be = 4'hF; addr = 5'd3; din = 32'hDEADBEEF;
    begin
      int n;
      n = 0;
      while (busy0 && n < 100) begin
        chk("busy_no_valid", {31'b0, valid0}, 0);
        n++;
        step();
      end
      cen = 0; wen = 0;
      chk("clr_busy_len", n, 32);
    end
    acc(0, 4'h0, 5'd3, 0);
    chk("clr_addr3", dout0, 0);

    // Reset mid-clear restarts the full clear
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 10; i++) step();
    reset = 1; step(); reset = 0;
    count_busy("busy_after_midreset");

    // Idle cycles hold S_dout
    acc(1, 4'hF, 5'd2, 32'h77);
    acc(0, 4'h0, 5'd2, 0);
    hold = dout0;
    chk("hold_src", hold, 32'h77);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle_hold", dout0, 32'h77);
      chk("idle_novalid", {31'b0, valid0}, 0);
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
